alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one instance of the team's 32-bit combinational `alu` between two requesters.
- Each requester issues an operation (A, B, ALUOp) over a valid/ready handshake.
- The block arbitrates round-robin, evaluates the granted operation, and registers the result in a one-entry output buffer with backpressure.
- Sits between the decode/issue logic and the shared ALU in the P-series datapath.

Parameters:
- None. Widths are fixed: A/B/result 32 bits, op 3 bits, to match `alu`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  operand A, requester 0.
- req0_b  input  32  operand B, requester 0.
- req0_op  input  3  ALUOp, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  output  1  result buffer holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_data  output  32  ALU result.
- rsp_id  output  1  requester that produced rsp_data.
- rsp_count  output  16  number of results consumed (rsp_valid && rsp_ready); wraps.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_count=0.
  - Round-robin pointer last_grant=1, so req0 wins the first tie.
  - Any buffered result is discarded.
  - req*_ready=0 while reset is high.
- State is the buffer flag:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only req0_valid → 0.
  - Only req1_valid → 1.
  - Both valid → !last_grant.
  - Neither valid → no grant.
- req_ready:
  - reqN_ready = can_accept && grant==N && reqN_valid.
  - At most one ready per cycle.
  - ready may depend on valid; valid must not depend on ready.
- Accept:
  - Occurs when the granted requester's valid && ready are both high.
  - On that clock edge: rsp_data <= alu(A,B,op) of the granted requester, rsp_id <= grant, rsp_valid <= 1, last_grant <= grant.
- Latency: result visible 1 cycle after accept.
- Throughput: 1 op/cycle. A drain and an accept in the same cycle go FULL → FULL with the new result.
- Drain without accept: FULL → EMPTY.
- Hold: while rsp_valid && !rsp_ready, rsp_data and rsp_id are held stable, and both ready outputs stay 0.
- last_grant changes only on accept. An unserved requester is never skipped, so a continuously valid requester waits at most 1 accept.
- ALU op encoding:
  - 000 → A+B (mod 2^32).
  - 001 → A−B (mod 2^32).
  - 010 → A&B.
  - 011 → A|B.
  - 100 → logical A>>B.
  - 101/110/111 → arithmetic A>>>B.
- Shift amount is the full 32-bit B: B≥32 gives 0 (logical) or 32 copies of A[31] (arithmetic).
- rsp_count: +1 on every edge with rsp_valid && rsp_ready. 0xFFFF wraps to 0x0000.
- Reset asserted mid-transfer: the pending result is lost, no ready is issued, and the count clears. After deassert, the first grant follows the reset pointer.

Test Plan:
- Reset, then req0 valid, op=000, A=5, B=7, rsp_ready=1 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0; rsp_count=1 one edge later.
- Both valid continuously, req0 op=001 A=3 B=5, req1 op=010 A=0xF0F0 B=0xFF00, rsp_ready=1 → grants alternate 0,1,0,1; results 0xFFFFFFFE and 0x0000F000 alternate back-to-back with no bubbles.
- Backpressure: accept one op, hold rsp_ready=0 for 4 cycles with both requesters valid → rsp_data/rsp_id stable, both ready=0. Raise rsp_ready → same-cycle accept of the next requester, rsp_valid stays 1.
- Shifts: A=0x80000000; op=100 B=4 → 0x08000000; op=101 B=4 → 0xF8000000; op=111 B=40 → 0xFFFFFFFF; op=100 B=32 → 0.
- Reset pulse mid-cycle while rsp_valid=1 → rsp_valid drops immediately (no clock edge needed). With both valid after release, req0 is granted first.
- Drive 65536 consumed results → rsp_count wraps to 0x0000.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one 32-bit combinational ALU between two requesters,
// with a one-entry registered result buffer that honours consumer backpressure.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);

  // Shifts use the full 32-bit b, so b >= 32 yields zero or sign fill.
  always_comb begin
    y = '0;
    case (op)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a >> b;
      default: y = 32'($signed(a) >>> b);
    endcase
  end

endmodule

module alu_rr_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic [15:0] rsp_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        grant_valid;
  logic        can_accept;
  logic        accept;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [2:0]  sel_op;
  logic [31:0] alu_y;

  // Arbitration and handshake; ready is suppressed while reset is held.
  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant       = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    can_accept  = (state == EMPTY) || rsp_ready;
    req0_ready  = !reset && can_accept && grant_valid && !grant && req0_valid;
    req1_ready  = !reset && can_accept && grant_valid &&  grant && req1_valid;
    accept      = req0_ready || req1_ready;
    sel_a       = grant ? req1_a  : req0_a;
    sel_b       = grant ? req1_b  : req0_b;
    sel_op      = grant ? req1_op : req0_op;
  end

  alu u_alu (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .y  (alu_y)
  );

  assign rsp_valid = (state == FULL);

  // Buffer state, result capture, pointer update and consumed-result count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_count  <= '0;
      last_grant <= 1'b1;
    end else begin
      if ((state == FULL) && rsp_ready) begin
        rsp_count <= rsp_count + 16'd1;
      end
      if (accept) begin
        state      <= FULL;
        rsp_data   <= alu_y;
        rsp_id     <= grant;
        last_grant <= grant;
      end else if (rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: ALU vector table plus arbitration,
// backpressure, async reset and count-wrap sequences.

module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [15:0] rsp_count;

  int total = 0;
  int bad   = 0;

  alu_rr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_count  (rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'd5,        32'd7,        3'b000, 32'd12};
    vecs[1]  = '{32'hFFFFFFFF, 32'd1,        3'b000, 32'h00000000};
    vecs[2]  = '{32'd3,        32'd5,        3'b001, 32'hFFFFFFFE};
    vecs[3]  = '{32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000};
    vecs[4]  = '{32'h0000F0F0, 32'h0000FF00, 3'b011, 32'h0000FFF0};
    vecs[5]  = '{32'h80000000, 32'd4,        3'b100, 32'h08000000};
    vecs[6]  = '{32'h80000000, 32'd4,        3'b101, 32'hF8000000};
    vecs[7]  = '{32'h80000000, 32'd40,       3'b111, 32'hFFFFFFFF};
    vecs[8]  = '{32'h80000000, 32'd32,       3'b100, 32'h00000000};
    vecs[9]  = '{32'h80000000, 32'd31,       3'b100, 32'h00000001};
    vecs[10] = '{32'h80000000, 32'd0,        3'b110, 32'h80000000};
    vecs[11] = '{32'h40000000, 32'd40,       3'b101, 32'h00000000};

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with requests pending to show ready stays low.
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_valid",  32'(rsp_valid),  32'd0);
    chk("rst_data",   rsp_data,        32'd0);
    chk("rst_id",     32'(rsp_id),     32'd0);
    chk("rst_count",  32'(rsp_count),  32'd0);
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // First transaction: 5 + 7 from requester 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000;
    #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data",  rsp_data,       32'd12);
    chk("t1_id",    32'(rsp_id),    32'd0);
    chk("t1_count", 32'(rsp_count), 32'd0);
    tick();
    chk("t1_drain", 32'(rsp_valid), 32'd0);
    chk("t1_count1", 32'(rsp_count), 32'd1);

    // ALU vector table through requester 0.
    for (int i = 0; i < 12; i++) begin
      req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].y);
      chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'd0);
      tick();
    end
    chk("vec_count", 32'(rsp_count), 32'd13);

    // Requester 1 alone.
    req1_valid = 1'b1; req1_a = 32'h00000011; req1_b = 32'h00000100; req1_op = 3'b011;
    #1;
    chk("r1_ready1", 32'(req1_ready), 32'd1);
    chk("r1_ready0", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    chk("r1_data", rsp_data,    32'h00000111);
    chk("r1_id",   32'(rsp_id), 32'd1);

    // Hold a result, then pulse reset between clock edges.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    tick();
    req0_valid = 1'b1;
    chk("rp_held", 32'(rsp_valid), 32'd1);
    req0_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rp_valid", 32'(rsp_valid), 32'd0);
    chk("rp_count", 32'(rsp_count), 32'd0);
    chk("rp_data",  rsp_data,       32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Both valid continuously: alternate 0,1,0,1 starting from the reset pointer.
    req0_valid = 1'b1; req0_a = 32'd3;        req0_b = 32'd5;        req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'h0000F0F0; req1_b = 32'h0000FF00; req1_op = 3'b010;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_ready1", i), 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("rr%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("rr%0d_id", i), 32'(rsp_id), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_data", i), rsp_data,
          (i % 2 == 1) ? 32'h0000F000 : 32'hFFFFFFFE);
    end
    chk("rr_count", 32'(rsp_count), 32'd3);

    // Backpressure for 4 cycles with both requesters still valid.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp%0d_ready0", i), 32'(req0_ready), 32'd0);
      chk($sformatf("bp%0d_ready1", i), 32'(req1_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_data", i), rsp_data,       32'h0000F000);
      chk($sformatf("bp%0d_id", i),   32'(rsp_id),    32'd1);
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
    end
    chk("bp_count", 32'(rsp_count), 32'd3);
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready0", 32'(req0_ready), 32'd1);
    chk("bp_rel_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rel_id",    32'(rsp_id),    32'd0);
    chk("bp_rel_data",  rsp_data,       32'hFFFFFFFE);
    chk("bp_rel_count", 32'(rsp_count), 32'd4);
    tick();
    chk("bp_end_valid", 32'(rsp_valid), 32'd0);
    chk("bp_end_count", 32'(rsp_count), 32'd5);

    // Count wrap: one accept edge, then 65536 consuming edges.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    rsp_ready = 1'b1;
    repeat (65536) tick();
    chk("wrap_ffff", 32'(rsp_count), 32'h0000FFFF);
    tick();
    chk("wrap_zero", 32'(rsp_count), 32'h00000000);
    req0_valid = 1'b0;
    tick();
    chk("wrap_one", 32'(rsp_count), 32'h00000001);
    chk("wrap_empty", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
